dsram_like_bridge: RTL and testbench
====================================

// Module: dsram_like_bridge
// PURPOSE
//  Converts the CPU core's single-cycle data-SRAM port (en/wen/addr/wdata/rdata)
//  into a split-transaction sram-like bus (req/addr_ok/data_ok) and stalls the core while waiting.
//  Sits directly downstream of the CPU top's data port.
//  Upstream of the bus arbiter / AXI converter.
//  Exactly one access is outstanding at any time.
// PARAMETERS
//  ADDR_W  32  address width, both sides
//  DATA_W  32  data width, both sides; wen width is DATA_W/8
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous reset, active-high
//  data_sram_en    in   1       CPU access request; held stable by CPU while d_stall=1
//  data_sram_wen   in   4       byte write enables; 0 = read
//  data_sram_addr  in   ADDR_W  CPU byte address
//  data_sram_wdata in   DATA_W  CPU write data
//  data_sram_rdata out  DATA_W  read data to CPU
//  ext_stall       in   1       pipeline frozen by another source
//  d_stall         out  1       stall request to CPU pipeline
//  data_req        out  1       bus request
//  data_wr         out  1       1 = write
//  data_size       out  2       0 = byte, 1 = half, 2 = word
//  data_addr       out  ADDR_W  bus address (pass-through of data_sram_addr)
//  data_wdata      out  DATA_W  bus write data (pass-through)
//  data_addr_ok    in   1       address accepted this cycle
//  data_data_ok    in   1       data returned/write complete this cycle
//  data_rdata      in   DATA_W  bus read data, valid with data_data_ok
// BEHAVIOUR
//  States: IDLE, ADDR, DATA, DONE. Reset -> IDLE.
//  Reset values: rdata_q = 0, data_sram_rdata = 0.
//  data_req = (IDLE & data_sram_en) | ADDR.
//  d_stall  = data_sram_en & (state != DONE).
//  data_wr  = |data_sram_wen.
//  data_size: wen 1111 -> 2; 0011 or 1100 -> 1; one-hot -> 0; read -> 2.
//    Other patterns are illegal; the assertion checker flags them.
//  IDLE: en=0 -> stay IDLE.
//    en=1 & !addr_ok -> ADDR.
//    en=1 & addr_ok & !data_ok -> DATA.
//    en=1 & addr_ok & data_ok -> DONE (zero-latency slave).
//  ADDR: addr_ok & data_ok -> DONE; addr_ok -> DATA; else hold. req stays 1.
//  DATA: req=0. data_ok -> DONE and rdata_q <= data_rdata; else hold.
//  data_data_ok outside DATA or a same-cycle accept is ignored.
//  DONE: req=0, d_stall=0 (CPU advances). data_sram_rdata = rdata_q.
//    ext_stall=1 -> stay DONE; the same access is not reissued.
//    ext_stall=0 -> IDLE.
//  Minimum latency: en to stall release is 1 cycle when addr_ok and data_ok arrive in the same cycle.
//  Reset mid-transaction: any state -> IDLE next edge and the access is abandoned.
//    The downstream bus is reset together with this block.
// CONFIGURATION
//  DSRAM_BRIDGE_FWD_EN defined:
//    In DATA or ADDR, when data_ok=1 this cycle, d_stall drops in the same cycle.
//    data_sram_rdata = data_rdata combinationally in that cycle; saves 1 cycle per access.
//    FSM still moves to DONE only if ext_stall=1, else directly to IDLE.
//  Not defined: data is always registered and returned in DONE, one cycle after data_ok.
//    No combinational path from the bus to the CPU.
// TESTING
//  1 Word store: en=1, wen=1111, addr=0x1000, wdata=0xDEADBEEF.
//    addr_ok on cycle 2, data_ok on cycle 4 -> req=1 for 2 cycles.
//    Bus sees wr=1, size=2, addr=0x1000; d_stall high 4 cycles then low in DONE.
//  2 Sub-word store: wen=0100 -> size=0. wen=1100 -> size=1. Addr passes through unchanged.
//  3 Load, 3-cycle latency, data_rdata=0x12345678 -> data_sram_rdata=0x12345678 in DONE.
//    With DSRAM_BRIDGE_FWD_EN, rdata appears on the data_ok cycle with d_stall=0.
//  4 Zero-latency slave (addr_ok=data_ok=1 in the same cycle as en) -> one req cycle, then DONE.
//    Back-to-back loads issue with exactly one idle req cycle between them.
//  5 ext_stall=1 for 5 cycles after DONE -> state holds DONE, req stays 0, rdata stable.
//    The access completes once on the bus.
//  6 rst=1 while in DATA -> next cycle IDLE, req=0, rdata=0.
//    A stray data_ok after reset is ignored.

Source files
------------

// File: rtl/dsram_like_bridge.sv
// Bridges the core's single-cycle data-SRAM port onto a split-transaction sram-like bus, one access in flight.
// Optional `DSRAM_BRIDGE_FWD_EN forwards bus read data to the core on the data_ok cycle.
module dsram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_sram_en,
  input  logic [DATA_W/8-1:0]   data_sram_wen,
  input  logic [ADDR_W-1:0]     data_sram_addr,
  input  logic [DATA_W-1:0]     data_sram_wdata,
  output logic [DATA_W-1:0]     data_sram_rdata,
  input  logic                  ext_stall,
  output logic                  d_stall,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t            state;
  logic [DATA_W-1:0] rdata_q;
  logic              finish_now;
  logic              fwd_hit;
  logic              wen_legal;
  state_t            after_finish;

  assign fsm_state  = state;
  assign data_addr  = data_sram_addr;
  assign data_wdata = data_sram_wdata;
  assign data_wr    = |data_sram_wen;
  assign data_req   = ((state == IDLE) && data_sram_en) || (state == ADDR);

  // The access completes in the cycle its data_ok is honoured.
  assign finish_now = ((state == IDLE) && data_sram_en && data_addr_ok && data_data_ok) ||
                      ((state == ADDR) && data_addr_ok && data_data_ok) ||
                      ((state == DATA) && data_data_ok);

`ifdef DSRAM_BRIDGE_FWD_EN
  assign fwd_hit = ((state == ADDR) && data_addr_ok && data_data_ok) ||
                   ((state == DATA) && data_data_ok);
  assign data_sram_rdata = fwd_hit ? data_rdata : rdata_q;
`else
  assign fwd_hit = 1'b0;
  assign data_sram_rdata = rdata_q;
`endif

  assign d_stall      = data_sram_en && (state != DONE) && !fwd_hit;
  assign after_finish = (fwd_hit && !ext_stall) ? IDLE : DONE;

  always_comb begin
    data_size = 2'd2;
    wen_legal = 1'b1;
    case (data_sram_wen)
      4'b1111, 4'b0000:                   data_size = 2'd2;
      4'b0011, 4'b1100:                   data_size = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: data_size = 2'd0;
      default:                            wen_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      if (finish_now && !data_wr) rdata_q <= data_rdata;
      case (state)
        IDLE: if (data_sram_en) begin
                if (data_addr_ok && data_data_ok) state <= DONE;
                else if (data_addr_ok)            state <= DATA;
                else                              state <= ADDR;
              end
        ADDR: if (data_addr_ok && data_data_ok) state <= after_finish;
              else if (data_addr_ok)            state <= DATA;
        DATA: if (data_data_ok) state <= after_finish;
        DONE: if (!ext_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  wen_pattern_legal: assert property (@(posedge clk) disable iff (rst) data_req |-> wen_legal);

endmodule

// File: tb/tb_dsram_like_bridge.sv
// Directed bench for dsram_like_bridge (default build, no read-data forwarding).
module tb_dsram_like_bridge;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr, wdata, sram_rdata;
  logic        ext_stall, d_stall, req, wr;
  logic [1:0]  size, fsm_state;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        addr_ok, data_ok;

  int vectors = 0;
  int miscompares = 0;
  int req_count;

  always #5 clk = ~clk;

  dsram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(sram_rdata),
    .ext_stall(ext_stall), .d_stall(d_stall),
    .data_req(req), .data_wr(wr), .data_size(size),
    .data_addr(bus_addr), .data_wdata(bus_wdata),
    .data_addr_ok(addr_ok), .data_data_ok(data_ok), .data_rdata(bus_rdata),
    .fsm_state(fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs shortly after the rising edge, then let outputs settle.
  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                       input logic aok, input logic dok, input logic [31:0] rd, input logic ext);
    @(posedge clk); #1;
    en = e; wen = w; addr = a; wdata = wd;
    addr_ok = aok; data_ok = dok; bus_rdata = rd; ext_stall = ext;
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = '0; ext_stall = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    chk("reset_rdata", sram_rdata, 32'h0);
    chk("reset_req", {31'd0, req}, 32'd0);
    chk("reset_stall", {31'd0, d_stall}, 32'd0);
    rst = 1'b0;

    // 1: word store, addr_ok one cycle late, data_ok two cycles after that
    drive(1, 4'hF, 32'h1000, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    chk("st_c1_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    chk("st_c1_req", {31'd0, req}, 32'd1);
    chk("st_c1_wr", {31'd0, wr}, 32'd1);
    chk("st_c1_size", {30'd0, size}, 32'd2);
    chk("st_c1_addr", bus_addr, 32'h1000);
    chk("st_c1_wdata", bus_wdata, 32'hDEADBEEF);
    chk("st_c1_stall", {31'd0, d_stall}, 32'd1);
    drive(1, 4'hF, 32'h1000, 32'hDEADBEEF, 1, 0, 32'h0, 0);
    chk("st_c2_state", {30'd0, fsm_state}, {30'd0, S_ADDR});
    chk("st_c2_req", {31'd0, req}, 32'd1);
    chk("st_c2_stall", {31'd0, d_stall}, 32'd1);
    drive(1, 4'hF, 32'h1000, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    chk("st_c3_state", {30'd0, fsm_state}, {30'd0, S_DATA});
    chk("st_c3_req", {31'd0, req}, 32'd0);
    chk("st_c3_stall", {31'd0, d_stall}, 32'd1);
    drive(1, 4'hF, 32'h1000, 32'hDEADBEEF, 0, 1, 32'h0, 0);
    chk("st_c4_state", {30'd0, fsm_state}, {30'd0, S_DATA});
    chk("st_c4_stall", {31'd0, d_stall}, 32'd1);
    drive(1, 4'hF, 32'h1000, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    chk("st_c5_state", {30'd0, fsm_state}, {30'd0, S_DONE});
    chk("st_c5_req", {31'd0, req}, 32'd0);
    chk("st_c5_stall", {31'd0, d_stall}, 32'd0);
    drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    chk("st_c6_state", {30'd0, fsm_state}, {30'd0, S_IDLE});

    // 2: sub-word stores against a zero-latency slave
    drive(1, 4'b0100, 32'h2003, 32'h00AB0000, 1, 1, 32'h0, 0);
    chk("sb_size", {30'd0, size}, 32'd0);
    chk("sb_addr", bus_addr, 32'h2003);
    chk("sb_req", {31'd0, req}, 32'd1);
    drive(1, 4'b0100, 32'h2003, 32'h00AB0000, 0, 0, 32'h0, 0);
    chk("sb_done", {30'd0, fsm_state}, {30'd0, S_DONE});
    drive(1, 4'b1100, 32'h2002, 32'hCDEF0000, 1, 1, 32'h0, 0);
    chk("sh_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    chk("sh_size", {30'd0, size}, 32'd1);
    chk("sh_addr", bus_addr, 32'h2002);
    chk("sh_wr", {31'd0, wr}, 32'd1);
    drive(1, 4'b1100, 32'h2002, 32'hCDEF0000, 0, 0, 32'h0, 0);
    chk("sh_done", {30'd0, fsm_state}, {30'd0, S_DONE});
    chk("sh_rdata_untouched", sram_rdata, 32'h0);
    drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

    // 3: load, data_ok three cycles after en
    drive(1, 4'h0, 32'h3000, 32'h0, 1, 0, 32'h0, 0);
    chk("ld_wr", {31'd0, wr}, 32'd0);
    chk("ld_size", {30'd0, size}, 32'd2);
    chk("ld_req", {31'd0, req}, 32'd1);
    drive(1, 4'h0, 32'h3000, 32'h0, 0, 0, 32'h0, 0);
    chk("ld_c2_state", {30'd0, fsm_state}, {30'd0, S_DATA});
    drive(1, 4'h0, 32'h3000, 32'h0, 0, 0, 32'h0, 0);
    drive(1, 4'h0, 32'h3000, 32'h0, 0, 1, 32'h12345678, 0);
    chk("ld_c4_stall", {31'd0, d_stall}, 32'd1);
    chk("ld_c4_rdata", sram_rdata, 32'h0);
    drive(1, 4'h0, 32'h3000, 32'h0, 0, 0, 32'hFFFFFFFF, 0);
    chk("ld_c5_state", {30'd0, fsm_state}, {30'd0, S_DONE});
    chk("ld_c5_rdata", sram_rdata, 32'h12345678);
    chk("ld_c5_stall", {31'd0, d_stall}, 32'd0);
    drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    chk("ld_hold_rdata", sram_rdata, 32'h12345678);

    // 4: back-to-back zero-latency loads
    drive(1, 4'h0, 32'h4000, 32'h0, 1, 1, 32'hA5A50001, 0);
    chk("zl1_req", {31'd0, req}, 32'd1);
    chk("zl1_stall", {31'd0, d_stall}, 32'd1);
    drive(1, 4'h0, 32'h4000, 32'h0, 0, 0, 32'h0, 0);
    chk("zl1_done", {30'd0, fsm_state}, {30'd0, S_DONE});
    chk("zl1_gap_req", {31'd0, req}, 32'd0);
    chk("zl1_rdata", sram_rdata, 32'hA5A50001);
    drive(1, 4'h0, 32'h4004, 32'h0, 1, 1, 32'h0000BEEF, 0);
    chk("zl2_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    chk("zl2_req", {31'd0, req}, 32'd1);
    drive(1, 4'h0, 32'h4004, 32'h0, 0, 0, 32'h0, 0);
    chk("zl2_rdata", sram_rdata, 32'h0000BEEF);
    drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

    // 5: ext_stall holds DONE; access must not be reissued
    req_count = 0;
    drive(1, 4'h0, 32'h5000, 32'h0, 1, 1, 32'h55AA55AA, 0);
    req_count += int'(req);
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'h0, 32'h5000, 32'h0, (i == 2), (i == 2), 32'hFFFFFFFF, 1);
      req_count += int'(req);
      chk("xs_state", {30'd0, fsm_state}, {30'd0, S_DONE});
      chk("xs_req", {31'd0, req}, 32'd0);
      chk("xs_rdata", sram_rdata, 32'h55AA55AA);
    end
    drive(1, 4'h0, 32'h5000, 32'h0, 0, 0, 32'h0, 0);
    req_count += int'(req);
    chk("xs_release_state", {30'd0, fsm_state}, {30'd0, S_DONE});
    drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    req_count += int'(req);
    chk("xs_idle", {30'd0, fsm_state}, {30'd0, S_IDLE});
    chk("xs_req_count", req_count, 32'd1);

    // 6: reset while waiting in DATA, then a stray data_ok
    drive(1, 4'h0, 32'h6000, 32'h0, 1, 0, 32'h0, 0);
    drive(1, 4'h0, 32'h6000, 32'h0, 0, 0, 32'h0, 0);
    chk("rs_in_data", {30'd0, fsm_state}, {30'd0, S_DATA});
    rst = 1'b1;
    drive(0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h99999999, 0);
    rst = 1'b0;
    #1;
    chk("rs_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    chk("rs_req", {31'd0, req}, 32'd0);
    chk("rs_rdata", sram_rdata, 32'h0);
    drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    chk("rs_stray_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    chk("rs_stray_rdata", sram_rdata, 32'h0);
    chk("rs_stray_stall", {31'd0, d_stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
